// File: rtl/fifo_converter_64to32b.sv
`default_nettype none
// ============================================================================
// Module   : fifo_converter_64to32b
// Purpose  : Read-back width converter. Drains 64-bit words from a FWFT
//            source FIFO and writes them as two 32-bit words (low half
//            first) into a downstream 32-bit FIFO, for a programmed number
//            of 64-bit words.
// Ports    : digiclk_i  - clock, rising edge
//            reset      - asynchronous active-high reset
//            start_i    - one-cycle transfer request (IDLE only)
//            xfer_len_i - number of 64-bit words to move
//            abort_i    - synchronous abort back to IDLE
//            src_empty  - source FIFO empty
//            src_64bit  - source FIFO head word
//            src_re     - source pop (combinational)
//            dst_afull  - destination almost-full
//            dst_we     - destination write enable (registered)
//            dst_32bit  - destination data (registered)
//            busy_o     - transfer in progress
//            done_o     - one-cycle completion pulse
//            word_cnt_o - 32-bit words written since reset (wrapping)
// Revision : 1.0 - initial release
// ============================================================================
module fifo_converter_64to32b #(
  parameter int LEN_W = 16,
  parameter int CNT_W = 17
) (
  input  logic             digiclk_i,
  input  logic             reset,
  input  logic             start_i,
  input  logic [LEN_W-1:0] xfer_len_i,
  input  logic             abort_i,
  input  logic             src_empty,
  input  logic [63:0]      src_64bit,
  output logic             src_re,
  input  logic             dst_afull,
  output logic             dst_we,
  output logic [31:0]      dst_32bit,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_words_left;
  logic [LEN_W-1:0] w_words_left_nxt;
  logic             r_dst_we;
  logic             w_dst_we_nxt;
  logic [31:0]      r_dst_data;
  logic [31:0]      w_dst_data_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [CNT_W-1:0] r_word_cnt;

  always_comb begin
    w_state_nxt      = r_state;
    w_words_left_nxt = r_words_left;
    w_dst_we_nxt     = 1'b0;
    w_dst_data_nxt   = r_dst_data;
    w_done_nxt       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (xfer_len_i != '0) begin
            w_words_left_nxt = xfer_len_i;
            w_state_nxt      = S_LOW;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_LOW: begin
        // The head word is only peeked here; it is popped with the high half.
        if (!src_empty && !dst_afull) begin
          w_dst_data_nxt = src_64bit[31:0];
          w_dst_we_nxt   = 1'b1;
          w_state_nxt    = S_HIGH;
        end
      end
      S_HIGH: begin
        // No empty check: the head word has not been popped yet.
        if (!dst_afull) begin
          w_dst_data_nxt   = src_64bit[63:32];
          w_dst_we_nxt     = 1'b1;
          w_words_left_nxt = r_words_left - LEN_W'(1);
          w_state_nxt      = (r_words_left == LEN_W'(1)) ? S_DONE : S_LOW;
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a pending done pulse.
    if (abort_i) begin
      w_state_nxt      = S_IDLE;
      w_dst_we_nxt     = 1'b0;
      w_words_left_nxt = '0;
      w_done_nxt       = 1'b0;
      w_dst_data_nxt   = r_dst_data;
    end
  end

  always_ff @(posedge digiclk_i or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_words_left <= '0;
      r_dst_we     <= 1'b0;
      r_dst_data   <= '0;
      r_done       <= 1'b0;
      r_word_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_words_left <= w_words_left_nxt;
      r_dst_we     <= w_dst_we_nxt;
      r_dst_data   <= w_dst_data_nxt;
      r_done       <= w_done_nxt;
      if (w_dst_we_nxt) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
    end
  end

  // Pop coincides with the edge that registers the high half.
  assign src_re     = (r_state == S_HIGH) && !dst_afull && !abort_i;
  assign busy_o     = (r_state == S_LOW) || (r_state == S_HIGH);
  assign dst_we     = r_dst_we;
  assign dst_32bit  = r_dst_data;
  assign done_o     = r_done;
  assign word_cnt_o = r_word_cnt;

endmodule
`default_nettype wire

// File: doc/fifo_converter_64to32b.md
# fifo_converter_64to32b

Read-back width converter for the DDR3 readout path. It drains 64-bit words from a first-word-fall-through (FWFT) FIFO loaded with data read from memory and writes them as 32-bit words into a downstream 32-bit FIFO, low half first. This is the unpacking counterpart of the 32-to-64 DIGIFIFO packer. A transfer covers a programmed number of 64-bit words and is flow-controlled by source-empty and destination-almost-full.

## Interface
- LEN_W, default 16: width of the transfer-length and remaining-word counters.
- CNT_W, default 17: width of the 32-bit-word-written counter.

- digiclk_i  in  1  clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle transfer request; sampled only in IDLE.
- xfer_len_i  in  LEN_W  number of 64-bit words to move; sampled with start_i.
- abort_i  in  1  synchronous abort; returns to IDLE from any state.
- src_empty  in  1  source FWFT FIFO empty.
- src_64bit  in  64  source FWFT head word; valid while ~src_empty.
- src_re  out  1  source pop, combinational.
- dst_afull  in  1  destination almost-full; asserted with at least 2 free slots left.
- dst_we  out  1  destination write enable, registered.
- dst_32bit  out  32  destination data, registered.
- busy_o  out  1  high in LOW and HIGH states.
- done_o  out  1  one-cycle pulse when a transfer completes; no pulse on abort.
- word_cnt_o  out  CNT_W  running count of 32-bit words written since reset; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, LOW, HIGH, DONE. Encoding is 2 bits. Unused codes go to IDLE with dst_we=0.
- IDLE:
  - dst_we=0.
  - On start_i with xfer_len_i≠0: load words_left←xfer_len_i, go to LOW.
  - On start_i with xfer_len_i=0: go to DONE. No source or destination activity.
- LOW:
  - If ~src_empty && ~dst_afull: dst_32bit←src_64bit[31:0], dst_we←1, go to HIGH.
  - Otherwise dst_we←0 and stay in LOW.
  - src_re=0 in this state. The head word stays at the FIFO head for the HIGH half.
- HIGH:
  - If ~dst_afull: dst_32bit←src_64bit[63:32], dst_we←1, src_re=1 in this same cycle, words_left←words_left−1.
  - Then go to DONE if words_left was 1, else go to LOW.
  - If dst_afull: dst_we←0, src_re=0, stay in HIGH.
  - Source emptiness is not rechecked in HIGH. The head word is guaranteed present because it has not been popped.
- DONE: done_o←1 for one cycle, dst_we←0, go to IDLE.
- Combinational outputs:
  - src_re = (state==HIGH) && ~dst_afull && ~abort_i.
  - busy_o = (state==LOW) || (state==HIGH).
- word_cnt_o increments by 1 on every cycle in which dst_we is registered high.
- abort_i has priority over all transitions:
  - Next state is IDLE, dst_we←0, words_left←0.
  - src_re is forced to 0.
  - An abort in HIGH leaves the half-sent 64-bit word at the source head. Flushing it is the caller's job.
- start_i outside IDLE is ignored.

## Timing
- Reset values: state=IDLE, dst_we=0, dst_32bit=0, done_o=0, words_left=0, word_cnt_o=0. Combinationally this gives src_re=0 and busy_o=0.
- Latency:
  - start_i to first dst_we: 2 cycles (IDLE→LOW, then LOW registers the write), given a non-empty source and a non-full destination.
  - Last dst_we to done_o: 1 cycle.
- Throughput: one 32-bit word per clock. An N-word transfer takes 2N cycles in LOW/HIGH when unstalled.
- dst_we is registered, so one write can land after dst_afull rises. The destination must therefore reserve 2 slots.
- src_re is combinational and pops at the same clock edge that registers the high half.
- Source empty in LOW: stall with no write and no pop. Resume on the first cycle src_empty=0.
- Simultaneous abort_i and start_i in IDLE: abort wins, state stays IDLE.

## Test plan
- Reset mid-transfer (in HIGH): all outputs return to their reset values immediately; the next start_i behaves normally.
- start_i, xfer_len_i=3, source holds 0x11111111_00000000, 0x33333333_22222222, 0x55555555_44444444, no stalls:
  - dst_32bit sequence is 0x00000000, 0x11111111, 0x22222222, 0x33333333, 0x44444444, 0x55555555 on 6 consecutive dst_we cycles.
  - Exactly 3 src_re pulses, one per HIGH write.
  - done_o pulses 1 cycle after the last write; word_cnt_o=6.
- dst_afull held for 5 cycles while in HIGH: no dst_we and no src_re during the stall; the high word is written unchanged afterward; order is preserved.
- src_empty for 4 cycles in LOW between words 1 and 2: busy_o stays 1 and there are no writes; the output sequence is identical to the unstalled case.
- start_i with xfer_len_i=0: done_o pulses 2 cycles later with no dst_we and no src_re. abort_i in HIGH: IDLE next cycle, no done_o, src_re not asserted, word_cnt_o stays at the low-half count.
